wb_scoreboard: RTL and testbench

- Writeback end of the register-file interface: the MEM/WB pipeline register, the writeback data mux, and a per-register pending-write scoreboard.
- Drives the write port that the decode stage's bypassing register file consumes: write enable, write select and write data.
- Also returns a RAW-hazard stall to decode for source registers with writes still in flight.
- Sits between the memory stage and the decode stage; one write retires per cycle.

---
 rtl/wb_scoreboard_pkg.sv | 28 ++
 rtl/pend_counter.sv | 33 +++
 rtl/wb_scoreboard.sv | 86 ++++++++
 tb/tb_wb_scoreboard.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_scoreboard_pkg.sv
// Shared widths, the MEM/WB bundle and the RAW-hazard rule for the writeback scoreboard.
// The MEM stage reuses mem_wb_t so both ends of the pipeline register agree on its layout.
package wb_scoreboard_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_SEL_W = 3;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [REG_SEL_W-1:0] dst;
        logic [DATA_W-1:0]    alu;
        logic [DATA_W-1:0]    rdata;
        logic                 dump;
    } mem_wb_t;

    // A source is busy if writes remain after any same-cycle retire, which the
    // register file bypasses to the reader.
    function automatic logic raw_busy(input logic [CNT_W-1:0] cnt, input logic retiring);
        return (cnt > CNT_W'(1)) || ((cnt == CNT_W'(1)) && !retiring);
    endfunction

endpackage

// File: rtl/pend_counter.sv
// One saturating up/down pending-write counter; an increment and decrement in
// the same cycle cancel, and overflow/underflow leave the count unchanged.
module pend_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow,
    output logic         underflow
);

    logic up;
    logic down;

    assign up        = inc & ~dec;
    assign down      = dec & ~inc;
    assign overflow  = up & (&count);
    assign underflow = down & ~(|count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (up && !overflow) begin
            count <= count + W'(1);
        end else if (down && !underflow) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback end of the register-file interface: MEM/WB register, writeback mux,
// and per-register pending-write scoreboard that raises the decode stall.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic                 issue_writes,
    input  logic [REG_SEL_W-1:0] issue_dst,
    input  logic [REG_SEL_W-1:0] src1_sel,
    input  logic                 src1_used,
    input  logic [REG_SEL_W-1:0] src2_sel,
    input  logic                 src2_used,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  logic                 mem_to_reg,
    input  logic [REG_SEL_W-1:0] mem_dst,
    input  logic [DATA_W-1:0]    mem_alu,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_dump,
    output logic                 reg_write,
    output logic [REG_SEL_W-1:0] reg_wr_sel,
    output logic [DATA_W-1:0]    write_data,
    output logic                 stall,
    output logic                 wb_dump,
    output logic                 err
);

    // Issue handshake: decode may assert issue_valid only while stall is low.
    // stall never looks at issue_valid, so there is no combinational loop.
    mem_wb_t wb_q;

    logic [NUM_REGS-1:0][CNT_W-1:0] pend;
    logic [NUM_REGS-1:0]            inc;
    logic [NUM_REGS-1:0]            dec;
    logic [NUM_REGS-1:0]            ovf;
    logic [NUM_REGS-1:0]            udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= '{valid: mem_valid, reg_write: mem_reg_write, mem_to_reg: mem_to_reg,
                      dst: mem_dst, alu: mem_alu, rdata: mem_rdata, dump: mem_dump};
        end
    end

    assign reg_write  = wb_q.valid & wb_q.reg_write;
    assign reg_wr_sel = wb_q.dst;
    assign write_data = wb_q.mem_to_reg ? wb_q.rdata : wb_q.alu;
    assign wb_dump    = wb_q.valid & wb_q.dump;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        assign inc[r] = issue_valid & issue_writes & (issue_dst == REG_SEL_W'(r));
        assign dec[r] = reg_write & (reg_wr_sel == REG_SEL_W'(r));

        pend_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .count     (pend[r]),
            .overflow  (ovf[r]),
            .underflow (udf[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((|ovf) || (|udf)) begin
            err <= 1'b1;
        end
    end

    logic src1_hazard;
    logic src2_hazard;
    logic dst_full;

    assign src1_hazard = src1_used & raw_busy(pend[src1_sel], reg_write && (reg_wr_sel == src1_sel));
    assign src2_hazard = src2_used & raw_busy(pend[src2_sel], reg_write && (reg_wr_sel == src2_sel));
    assign dst_full    = issue_writes & (pend[issue_dst] == CNT_MAX);
    assign stall       = src1_hazard | src2_hazard | dst_full;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized legal
// traffic, all compared against a count-based reference model.
module tb_wb_scoreboard;
    import wb_scoreboard_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid, issue_writes;
    logic [REG_SEL_W-1:0] issue_dst, src1_sel, src2_sel, mem_dst;
    logic                 src1_used, src2_used;
    logic                 mem_valid, mem_reg_write, mem_to_reg, mem_dump;
    logic [DATA_W-1:0]    mem_alu, mem_rdata;
    logic                 reg_write, stall, wb_dump, err;
    logic [REG_SEL_W-1:0] reg_wr_sel;
    logic [DATA_W-1:0]    write_data;

    wb_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dst(issue_dst),
        .src1_sel(src1_sel), .src1_used(src1_used), .src2_sel(src2_sel), .src2_used(src2_used),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg),
        .mem_dst(mem_dst), .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_dump(mem_dump),
        .reg_write(reg_write), .reg_wr_sel(reg_wr_sel), .write_data(write_data),
        .stall(stall), .wb_dump(wb_dump), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: counts of outstanding writes and the previous MEM presentation
    logic [DATA_W-1:0] exp_q[$];
    int  pend_m[NUM_REGS];
    bit  err_m;
    bit  wbv_m, wbrw_m, wbdump_m;
    int  wbdst_m;
    int  issued_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_retiring(int r);
        return wbv_m && wbrw_m && (wbdst_m == r);
    endfunction

    function automatic bit model_src_busy(int s);
        return (pend_m[s] >= 2) || (pend_m[s] == 1 && !model_retiring(s));
    endfunction

    function automatic bit model_stall();
        bit h = 0;
        if (src1_used && model_src_busy(int'(src1_sel))) h = 1;
        if (src2_used && model_src_busy(int'(src2_sel))) h = 1;
        if (issue_writes && pend_m[int'(issue_dst)] == 3) h = 1;
        return h;
    endfunction

    task automatic model_reset();
        foreach (pend_m[r]) pend_m[r] = 0;
        err_m = 0; wbv_m = 0; wbrw_m = 0; wbdump_m = 0; wbdst_m = 0;
        exp_q.delete();
        exp_q.push_back('0);
        issued_q.delete();
    endtask

    task automatic model_step();
        for (int r = 0; r < NUM_REGS; r++) begin
            bit up, down;
            up   = issue_valid && issue_writes && (int'(issue_dst) == r);
            down = model_retiring(r);
            if (up && !down) begin
                if (pend_m[r] == 3) err_m = 1; else pend_m[r]++;
            end else if (down && !up) begin
                if (pend_m[r] == 0) err_m = 1; else pend_m[r]--;
            end
        end
        wbv_m    = mem_valid;
        wbrw_m   = mem_reg_write;
        wbdst_m  = int'(mem_dst);
        wbdump_m = mem_dump;
        void'(exp_q.pop_front());
        exp_q.push_back(mem_to_reg ? mem_rdata : mem_alu);
    endtask

    task automatic check_outputs();
        check("reg_write", reg_write, wbv_m && wbrw_m);
        check("reg_wr_sel", reg_wr_sel, wbdst_m);
        check("write_data", write_data, exp_q[0]);
        check("wb_dump", wb_dump, wbv_m && wbdump_m);
        check("stall", stall, model_stall());
        check("err", err, err_m);
        for (int r = 0; r < NUM_REGS; r++)
            check($sformatf("pend%0d", r), dut.pend[r], pend_m[r]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reg_write"}, reg_write, 0);
        check({tag, "_write_data"}, write_data, 0);
        check({tag, "_wb_dump"}, wb_dump, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // called at the falling edge with inputs already driven
    task automatic cycle();
        #1;
        if (rst_n) check_outputs(); else check_reset_outputs("rst");
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
    endtask

    // driver tasks
    task automatic idle();
        issue_valid = 0; issue_writes = 0; issue_dst = 0;
        src1_sel = 0; src1_used = 0; src2_sel = 0; src2_used = 0;
        mem_valid = 0; mem_reg_write = 0; mem_to_reg = 0; mem_dst = 0;
        mem_alu = 0; mem_rdata = 0; mem_dump = 0;
    endtask

    task automatic issue(input int dst);
        issue_valid = 1; issue_writes = 1; issue_dst = REG_SEL_W'(dst);
    endtask

    task automatic mem_wr(input int dst, input logic [DATA_W-1:0] alu,
                          input logic [DATA_W-1:0] rdata, input bit m2r);
        mem_valid = 1; mem_reg_write = 1; mem_dst = REG_SEL_W'(dst);
        mem_alu = alu; mem_rdata = rdata; mem_to_reg = m2r;
    endtask

    task automatic random_cycle();
        idle();
        if (issued_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            mem_wr(issued_q.pop_front(), DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end else begin
            mem_valid     = 1'($urandom_range(0, 1));
            mem_reg_write = 0;
            mem_dst       = REG_SEL_W'($urandom_range(0, NUM_REGS - 1));
            mem_alu       = DATA_W'($urandom);
            mem_rdata     = DATA_W'($urandom);
            mem_to_reg    = 1'($urandom_range(0, 1));
        end
        mem_dump     = ($urandom_range(0, 15) == 0);
        src1_sel     = REG_SEL_W'($urandom_range(0, NUM_REGS - 1));
        src1_used    = 1'($urandom_range(0, 1));
        src2_sel     = REG_SEL_W'($urandom_range(0, NUM_REGS - 1));
        src2_used    = 1'($urandom_range(0, 1));
        issue_writes = ($urandom_range(0, 3) != 0);
        issue_dst    = REG_SEL_W'($urandom_range(0, NUM_REGS - 1));
        issue_valid  = !model_stall() && ($urandom_range(0, 2) != 0);
        if (issue_valid && issue_writes) issued_q.push_back(int'(issue_dst));
        cycle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();

        // reset held with a valid MEM write present
        @(negedge clk);
        mem_wr(3, 16'hAAAA, 16'h5555, 0);
        cycle();
        cycle();
        rst_n = 1;
        idle();
        cycle();

        // writeback latency, ALU then memory data
        issue(3); cycle();
        issue(3); cycle();
        idle(); mem_wr(3, 16'h1234, 16'h0000, 0); cycle();
        idle(); mem_wr(3, 16'h0000, 16'hBEEF, 1);
        #1 check("lat_alu_we", reg_write, 1);
        check("lat_alu_sel", reg_wr_sel, 3);
        check("lat_alu_data", write_data, 16'h1234);
        cycle();
        idle();
        #1 check("lat_mem_data", write_data, 16'hBEEF);
        cycle();

        // RAW stall released by same-cycle retire
        issue(2); cycle();
        idle(); src1_sel = 2; src1_used = 1;
        #1 check("raw_stall", stall, 1);
        cycle();
        mem_wr(2, 16'h0002, 0, 0); cycle();
        mem_valid = 0; mem_reg_write = 0;
        #1 check("raw_release", stall, 0);
        cycle();
        #1 check("raw_pend2", dut.pend[2], 0);
        cycle();

        // two writes in flight to r5
        idle(); issue(5); cycle();
        issue(5); cycle();
        idle(); src1_sel = 5; src1_used = 1;
        mem_wr(5, 16'h0051, 0, 0); cycle();
        mem_wr(5, 16'h0052, 0, 0);
        #1 check("two_first_retire_stall", stall, 1);
        cycle();
        mem_valid = 0; mem_reg_write = 0;
        #1 check("two_second_retire_stall", stall, 0);
        cycle();

        // simultaneous issue and retire on r4
        idle(); issue(4); cycle();
        idle(); mem_wr(4, 16'h0004, 0, 0); cycle();
        idle(); issue(4); cycle();
        idle();
        #1 check("simul_pend4", dut.pend[4], 1);
        check("simul_err", err, 0);
        mem_wr(4, 16'h0044, 0, 0); cycle();
        idle(); cycle();

        // randomized legal traffic
        for (int i = 0; i < 2000; i++) random_cycle();
        idle();
        while (issued_q.size() > 0) begin
            idle();
            mem_wr(issued_q.pop_front(), DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));
            cycle();
        end
        idle(); cycle(); cycle();
        #1 check("random_no_err", err, 0);
        cycle();

        // underflow on r6, sticky
        idle(); mem_wr(6, 16'h0006, 0, 0); cycle();
        idle(); cycle();
        #1 check("underflow_err", err, 1);
        cycle(); cycle();
        #1 check("err_sticky", err, 1);
        cycle();

        // overflow on r7 with the stall ignored
        issue(7); cycle();
        issue(7); cycle();
        issue(7); cycle();
        issue(7);
        #1 check("full_stall", stall, 1);
        cycle();
        idle();
        #1 check("ovf_pend7", dut.pend[7], 3);
        check("ovf_err", err, 1);
        cycle();

        // asynchronous reset mid-cycle with a write sitting in MEM/WB
        mem_wr(1, 16'h7777, 16'h8888, 0); cycle();
        idle();
        #2 rst_n = 0;
        #1 check_reset_outputs("async");
        check("async_pend7", dut.pend[7], 0);
        model_reset();
        @(negedge clk);
        mem_wr(1, 16'h1111, 0, 0);
        cycle();
        rst_n = 1;
        idle(); cycle();
        issue(0); cycle();
        idle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
